// File: rtl/frame_serializer_if.sv
// Pixel source handshake: din/value from the source, din_rd back.
// master = pixel source, slave = serializer.
interface frame_serializer_if #(
  parameter int PIXEL = 24
) ();
  logic [PIXEL-1:0] din;
  logic             value;
  logic             din_rd;

  modport master (
    output din,
    output value,
    input  din_rd
  );

  modport slave (
    input  din,
    input  value,
    output din_rd
  );
endinterface

// File: rtl/frame_serializer.sv
// Framed multi-lane pixel serializer: SYNC / ACTIVE / HBLANK / VBLANK.
// Ports: clkin, rst_n, pix (slave handshake), dout, frame_start,
//        line_active, pix_strobe, err_underrun (all outputs registered).
module frame_serializer #(
  parameter int ROW      = 1024,
  parameter int COL      = 1280,
  parameter int PIXEL    = 24,
  parameter int LANES    = 4,
  parameter int SYNC_LEN = 8,
  parameter int HBLANK   = 16,
  parameter int VBLANK   = 32
) (
  input  logic               clkin,
  input  logic               rst_n,
  frame_serializer_if.slave  pix,
  output logic [LANES-1:0]   dout,
  output logic               frame_start,
  output logic               line_active,
  output logic               pix_strobe,
  output logic               err_underrun
);
  localparam int BPL  = PIXEL / LANES;
  localparam int PMAX =
    (SYNC_LEN > HBLANK)
      ? ((SYNC_LEN > VBLANK) ? SYNC_LEN : VBLANK)
      : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int BW = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  typedef enum logic [1:0] {
    S_SYNC, S_ACTIVE, S_HBLANK, S_VBLANK
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]    ph;
  logic [BW-1:0]    bit_c;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIXEL-1:0] hold, shreg, src, shreg_nx;
  logic             hold_full, hold_full_nx;
  logic             ph_last, line_last;
  logic             slot_start, drain, capture;
  logic [LANES-1:0] dout_nx;
  logic             fs_nx, la_nx, ps_nx, err_nx;

  function automatic logic [LANES-1:0] lane_msb(
    input logic [PIXEL-1:0] p
  );
    logic [LANES-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[k] = p[k*BPL + BPL - 1];
    return r;
  endfunction

  // Shift every lane left by one; the bit that crosses
  // into the bottom of the next lane is cleared.
  function automatic logic [PIXEL-1:0] lane_shl(
    input logic [PIXEL-1:0] p
  );
    logic [PIXEL-1:0] r;
    r = p << 1;
    for (int k = 0; k < LANES; k++)
      r[k*BPL] = 1'b0;
    return r;
  endfunction

  always_comb begin
    ph_last = 1'b0;
    unique case (state)
      S_SYNC:   ph_last = (ph == PW'(SYNC_LEN - 1));
      S_HBLANK: ph_last = (ph == PW'(HBLANK - 1));
      S_VBLANK: ph_last = (ph == PW'(VBLANK - 1));
      default:  ph_last = 1'b0;
    endcase
  end

  assign line_last = (bit_c == BW'(BPL - 1)) &&
                     (col == CW'(COL - 1));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_SYNC:
        if (ph_last) state_nx = S_ACTIVE;
      S_ACTIVE:
        if (line_last)
          state_nx = (row < RW'(ROW - 1)) ?
                     S_HBLANK : S_VBLANK;
      S_HBLANK:
        if (ph_last) state_nx = S_ACTIVE;
      S_VBLANK:
        if (ph_last) state_nx = S_SYNC;
      default: state_nx = S_SYNC;
    endcase
  end

  // Holding register empties only on a slot load, so a
  // capture (needs empty) and a drain (needs full) are
  // never on the same edge.
  assign slot_start   = (state == S_ACTIVE) && (bit_c == '0);
  assign drain        = slot_start && hold_full;
  assign capture      = pix.din_rd && pix.value;
  assign hold_full_nx = capture || (hold_full && !drain);

  always_comb begin
    src      = slot_start ? (hold_full ? hold : '0) : shreg;
    shreg_nx = lane_shl(src);
    fs_nx    = (state == S_SYNC) && (ph == '0);
    la_nx    = (state == S_ACTIVE);
    ps_nx    = slot_start;
    err_nx   = err_underrun || (slot_start && !hold_full);
    dout_nx  = '0;
    unique case (state)
      S_SYNC:   dout_nx = '1;
      S_ACTIVE: dout_nx = lane_msb(src);
      default:  dout_nx = '0;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= '0;
      bit_c <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      ph <= (state == S_ACTIVE || ph_last) ?
            '0 : ph + 1'b1;
      if (state == S_ACTIVE) begin
        if (bit_c == BW'(BPL - 1)) begin
          bit_c <= '0;
          col   <= (col == CW'(COL - 1)) ?
                   '0 : col + 1'b1;
        end else begin
          bit_c <= bit_c + 1'b1;
        end
      end
      if (state == S_HBLANK && ph_last)
        row <= row + 1'b1;
      if (state == S_VBLANK && ph_last)
        row <= '0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      shreg        <= '0;
      pix.din_rd   <= 1'b0;
      dout         <= '0;
      frame_start  <= 1'b0;
      line_active  <= 1'b0;
      pix_strobe   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (capture) hold <= pix.din;
      hold_full    <= hold_full_nx;
      shreg        <= shreg_nx;
      // Request drops during the load edge and returns
      // one edge later.
      pix.din_rd   <= !hold_full_nx && !drain;
      dout         <= dout_nx;
      frame_start  <= fs_nx;
      line_active  <= la_nx;
      pix_strobe   <= ps_nx;
      err_underrun <= err_nx;
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: randomized source against a
// frame-position reference model, all outputs checked each cycle.
module tb_frame_serializer;
  localparam int ROW      = 2;
  localparam int COL      = 3;
  localparam int PIXEL    = 24;
  localparam int LANES    = 4;
  localparam int SYNC_LEN = 4;
  localparam int HBLANK   = 2;
  localparam int VBLANK   = 3;
  localparam int BPL      = PIXEL / LANES;
  localparam int LP       = COL * BPL + HBLANK;
  localparam int PERIOD   = SYNC_LEN + ROW * COL * BPL +
                            (ROW - 1) * HBLANK + VBLANK;

  logic             clkin = 1'b0;
  logic             rst_n = 1'b0;
  logic [LANES-1:0] dout;
  logic             frame_start, line_active;
  logic             pix_strobe, err_underrun;

  frame_serializer_if #(.PIXEL(PIXEL)) pif ();

  frame_serializer #(
    .ROW(ROW), .COL(COL), .PIXEL(PIXEL), .LANES(LANES),
    .SYNC_LEN(SYNC_LEN), .HBLANK(HBLANK), .VBLANK(VBLANK)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .pix(pif.slave),
    .dout(dout),
    .frame_start(frame_start),
    .line_active(line_active),
    .pix_strobe(pix_strobe),
    .err_underrun(err_underrun)
  );

  always #5 clkin = ~clkin;

  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;
  int last_fs = -1;
  int mode = 0;
  int next_seq = 1;

  logic             m_rd, m_held, m_err;
  logic [PIXEL-1:0] m_hold_pix, m_cur;
  int               m_tc;
  logic [LANES-1:0] exp_dout;
  logic             exp_fs, exp_la, exp_ps;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  // kind: 0 sync, 1 active, 2 hblank, 3 vblank;
  // c = bit position within the pixel slot.
  task automatic classify(input int t,
                          output int kind,
                          output int c);
    int p, q;
    kind = 3;
    c = 0;
    if (t < SYNC_LEN) begin
      kind = 0;
    end else begin
      p = t - SYNC_LEN;
      if (p < ROW * LP - HBLANK) begin
        q = p % LP;
        if (q < COL * BPL) begin
          kind = 1;
          c = q % BPL;
        end else begin
          kind = 2;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_held = 0; m_err = 0;
    m_hold_pix = '0; m_cur = '0; m_tc = 0;
    exp_dout = '0; exp_fs = 0; exp_la = 0; exp_ps = 0;
    last_fs = -1;
  endtask

  // Outcome of the next rising edge, given current inputs.
  task automatic model_step();
    int kind, c;
    logic xfer, drained;
    xfer = m_rd && pif.value;
    classify(m_tc, kind, c);
    exp_fs = (m_tc == 0);
    exp_la = (kind == 1);
    exp_ps = (kind == 1) && (c == 0);
    drained = 0;
    if (exp_ps) begin
      if (m_held) begin
        m_cur = m_hold_pix;
        m_held = 0;
        drained = 1;
      end else begin
        m_cur = '0;
        m_err = 1;
      end
    end
    exp_dout = '0;
    if (kind == 0) exp_dout = '1;
    if (kind == 1)
      for (int k = 0; k < LANES; k++)
        exp_dout[k] = m_cur[k*BPL + BPL - 1 - c];
    if (xfer) begin
      m_held = 1;
      m_hold_pix = pif.din;
      if (mode == 1) next_seq++;
    end
    m_rd = !m_held && !drained;
    m_tc = (m_tc + 1) % PERIOD;
  endtask

  task automatic compare_all();
    check("dout", 32'(dout), 32'(exp_dout));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("line_active", 32'(line_active), 32'(exp_la));
    check("pix_strobe", 32'(pix_strobe), 32'(exp_ps));
    check("err_underrun", 32'(err_underrun), 32'(m_err));
    check("din_rd", 32'(pif.din_rd), 32'(m_rd));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0)
        check("period", 32'(cyc - last_fs), 32'(PERIOD));
      last_fs = cyc;
    end
  endtask

  task automatic drive();
    case (mode)
      0: begin
        pif.value = 1;
        pif.din = 24'hFC0FC0;
      end
      1: begin
        pif.value = 1;
        pif.din = PIXEL'(next_seq);
      end
      2: begin
        pif.value = !(cyc >= 5 && cyc <= 14);
        pif.din = PIXEL'($urandom);
      end
      default: begin
        pif.value = ($urandom_range(3) != 0);
        pif.din = PIXEL'($urandom);
      end
    endcase
  endtask

  task automatic one_cycle();
    drive();
    model_step();
    @(negedge clkin);
    cyc++;
    compare_all();
  endtask

  task automatic hold_reset(input int n);
    rst_n = 0;
    model_reset();
    pif.value = 0;
    repeat (n) begin
      @(negedge clkin);
      compare_all();
    end
  endtask

  task automatic release_reset();
    rst_n = 1;
    cyc = -1;
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    if (m == 1) next_seq = 1;
    repeat (n) one_cycle();
  endtask

  initial begin
    pif.value = 0;
    pif.din = '0;
    hold_reset(3);

    release_reset();
    run(0, 2 * PERIOD + 5);

    hold_reset(2);
    release_reset();
    run(1, PERIOD + 5);

    hold_reset(2);
    release_reset();
    run(2, 2 * PERIOD + 2);

    hold_reset(2);
    release_reset();
    mode = 2;
    while (cyc < 30) one_cycle();
    hold_reset(2);
    release_reset();
    run(3, 60);

    run(3, 3 * PERIOD);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
